// File: rtl/spi_ctrl_bank.sv
// SPI-slave control register bank: addressed write frames over a 3-wire link, NREG words of BITS.
// Define SPI_CTRL_READBACK_EN to build MISO readback; otherwise CTRL_MISO is tied low.
module spi_ctrl_bank #(
  parameter int              BITS    = 8,
  parameter int              NREG    = 8,
  parameter int              ADDR_W  = 3,
  parameter logic [BITS-1:0] RST_VAL = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 CTRL_SCLK,
  input  logic                 CTRL_MOSI,
  input  logic                 CTRL_SS_n,
  output logic                 CTRL_MISO,
  output logic [NREG*BITS-1:0] regs,
  output logic                 upd_stb,
  output logic [ADDR_W-1:0]    upd_addr,
  output logic                 frame_err
);
  localparam int FRAME = ADDR_W + BITS;
  localparam int CNT_W = $clog2(FRAME + 2);
  localparam int AW1   = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ADDR  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME + 1);
  localparam logic [AW1-1:0]   NREG_L    = AW1'(NREG);

  localparam logic [1:0] WAIT_IDLE = 2'd0;
  localparam logic [1:0] IDLE      = 2'd1;
  localparam logic [1:0] SHIFT     = 2'd2;

  // [0] and [1] form the synchronizer, [2] is the edge-detect history
  logic [2:0] sclk_sync, mosi_sync, ss_sync;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], CTRL_SCLK};
      mosi_sync <= {mosi_sync[1:0], CTRL_MOSI};
      ss_sync   <= {ss_sync[1:0], CTRL_SS_n};
    end
  end

  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign ss_rise   = ss_sync[1] & ~ss_sync[2];
  assign ss_fall   = ~ss_sync[1] & ss_sync[2];

  logic [1:0]       state;
  logic [FRAME-1:0] sh_q, sh_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic             frame_ok;

  // A bit arriving in the same cycle as SS_n rise is shifted before evaluation
  always_comb begin
    sh_nxt  = sh_q;
    cnt_nxt = cnt_q;
    if (sclk_rise) begin
      sh_nxt = {sh_q[FRAME-2:0], mosi_sync[2]};
      if (cnt_q != CNT_MAX) cnt_nxt = cnt_q + CNT_W'(1);
    end
  end

  assign addr_nxt = sh_nxt[FRAME-1 -: ADDR_W];
  assign frame_ok = (cnt_nxt == CNT_FRAME) && ({1'b0, addr_nxt} < NREG_L);

  // Stage p0: frame evaluation at SS_n rise
  logic              commit_p0, err_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [BITS-1:0]   data_p0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= WAIT_IDLE;
      cnt_q     <= '0;
      commit_p0 <= 1'b0;
      err_p0    <= 1'b0;
    end else begin
      commit_p0 <= 1'b0;
      err_p0    <= 1'b0;
      case (state)
        WAIT_IDLE: if (ss_sync[1]) state <= IDLE;
        IDLE: begin
          if (ss_fall) begin
            state <= SHIFT;
            cnt_q <= '0;
          end
        end
        SHIFT: begin
          cnt_q <= cnt_nxt;
          if (ss_rise) begin
            state     <= IDLE;
            commit_p0 <= frame_ok;
            err_p0    <= ~frame_ok;
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && ss_fall) sh_q <= '0;
    else if (state == SHIFT)      sh_q <= sh_nxt;
    if (state == SHIFT && ss_rise) begin
      addr_p0 <= addr_nxt;
      data_p0 <= sh_nxt[BITS-1:0];
    end
  end

  // Stage p1: register commit and status pulses
  logic [BITS-1:0] reg_q [NREG];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NREG; k++) reg_q[k] <= RST_VAL;
      upd_stb   <= 1'b0;
      upd_addr  <= '0;
      frame_err <= 1'b0;
    end else begin
      upd_stb   <= commit_p0;
      frame_err <= err_p0;
      if (commit_p0) upd_addr <= addr_p0;
      for (int k = 0; k < NREG; k++)
        if (commit_p0 && addr_p0 == ADDR_W'(k)) reg_q[k] <= data_p0;
    end
  end

  for (genvar k = 0; k < NREG; k++) begin : g_out
    assign regs[k*BITS +: BITS] = reg_q[k];
  end

`ifdef SPI_CTRL_READBACK_EN
  logic [BITS-1:0] rd_word, rd_sh;
  logic            miso_q;

  // Word is latched on the fall after the last address bit; out-of-range reads as zero
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NREG; k++)
      if (sh_q[ADDR_W-1:0] == ADDR_W'(k)) rd_word = reg_q[k];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miso_q <= 1'b0;
      rd_sh  <= '0;
    end else if (state != SHIFT || ss_sync[1]) begin
      miso_q <= 1'b0;
    end else if (sclk_fall) begin
      if (cnt_q == CNT_ADDR) begin
        miso_q <= rd_word[BITS-1];
        rd_sh  <= rd_word << 1;
      end else if (cnt_q > CNT_ADDR && cnt_q < CNT_FRAME) begin
        miso_q <= rd_sh[BITS-1];
        rd_sh  <= rd_sh << 1;
      end
    end
  end

  assign CTRL_MISO = miso_q;
`else
  assign CTRL_MISO = 1'b0;
`endif

endmodule

// File: doc/spi_ctrl_bank.md
# spi_ctrl_bank

Parametrised SPI-slave control register bank for the theremin FPGA. Receives addressed write frames from the control MCU over a 3-wire SPI link (SCLK/MOSI/SS_n, asynchronous to `clk`) and holds NREG control words of BITS width for the tone, delay and gain paths. Adds addressing, frame-length checking, an update strobe and optional MISO readback. Default map: 0 a16, 1 a8, 2 a5, 3 a4, 4 blend, 5 delay, 6 feedbk, 7 gain.

## Interface
- BITS, 8, width of each control word
- NREG, 8, number of registers; must satisfy 1 ≤ NREG ≤ 2**ADDR_W
- ADDR_W, 3, address field width in the frame
- RST_VAL, 0, reset value of every register (BITS wide)
- clk  input  1  system clock, rising edge; one clock; reset is asynchronous and active-low
- reset_n  input  1  asynchronous active-low reset
- CTRL_SCLK  input  1  SPI clock, async, mode 0
- CTRL_MOSI  input  1  SPI data in, async
- CTRL_SS_n  input  1  SPI select, active-low, async
- CTRL_MISO  output  1  SPI data out (readback, see Configuration)
- regs  output  NREG*BITS  register k at `[k*BITS +: BITS]`
- upd_stb  output  1  one-cycle pulse on register commit
- upd_addr  output  ADDR_W  address of last committed register
- frame_err  output  1  one-cycle pulse on a discarded frame

## Operation
- CTRL_SCLK, CTRL_MOSI, CTRL_SS_n each pass through a 2-FF synchronizer plus one history FF; edges are detected as `s2 & ~s3` (rise) and `~s2 & s3` (fall).
- Frame: FRAME = ADDR_W + BITS bits, MSB first; address then data. MOSI is sampled on each detected SCLK rise while synchronized SS_n is low.
- States: WAIT_IDLE, IDLE, SHIFT.
  - WAIT_IDLE (after reset): stays until synchronized SS_n is high, then IDLE. A frame in progress at reset release is ignored.
  - IDLE: SS_n fall → SHIFT; shift register and bit counter cleared.
  - SHIFT: each SCLK rise shifts in 1 bit, counter +1, saturating at FRAME+1. SS_n rise → IDLE with evaluation:
    - count == FRAME and addr < NREG: regs[addr] ← data, upd_stb = 1, upd_addr = addr.
    - otherwise (short, long, or addr ≥ NREG): no register change, frame_err = 1.
- If an SCLK rise and an SS_n rise are detected in the same cycle, the bit is shifted first and is included in the evaluation.
- SCLK edges while SS_n is high are ignored.
- Reset (any time, including mid-frame): regs = RST_VAL in every slot, upd_stb = 0, upd_addr = 0, frame_err = 0, CTRL_MISO = 0, state WAIT_IDLE.

## Timing
- Constraint: clk frequency ≥ 8× SCLK frequency; SCLK high and low times ≥ 3 clk periods; SS_n high time between frames ≥ 3 clk periods.
- Commit latency: regs, upd_stb and upd_addr update on the 4th clk rising edge counted from the edge at which the first synchronizer FF captures SS_n high. frame_err has the same latency.
- upd_stb and frame_err are high for exactly one cycle and are mutually exclusive.
- regs are held stable between commits; only one slot changes per commit.

## Configuration
- `SPI_CTRL_READBACK_EN` defined:
  - During the data phase (after ADDR_W bits have been received), CTRL_MISO shifts out the current value of regs[addr] MSB first.
  - CTRL_MISO changes 1 clk after each detected SCLK fall, so the master samples it on the next SCLK rise.
  - The first data bit is driven after the detected fall that follows the last address bit.
  - addr ≥ NREG reads as all zeros.
  - CTRL_MISO = 0 whenever SS_n is high.
- Not defined: CTRL_MISO is tied to 0 and no readback logic is built. Write behaviour is identical in both builds.

## Test plan
- Reset check: after reset, all 8 regs = 0x00, upd_stb = 0, CTRL_MISO = 0.
- Valid write: frame addr = 5, data = 0xA7 (11 bits) → regs slot 5 = 0xA7, upd_stb pulses once, upd_addr = 5, other slots unchanged.
- Length errors:
  - 10-bit frame → frame_err pulses, no register change.
  - 12-bit frame → frame_err pulses, no register change.
- Out-of-range address: NREG = 6, frame to addr = 7 → frame_err pulses, no change. Same-cycle SCLK rise and SS_n rise on the last bit → commit occurs.
- Reset mid-frame: reset_n asserted after 5 bits, released while SS_n is still low, remaining bits sent → no commit (WAIT_IDLE). Next full frame addr = 0, data = 0x3C → slot 0 = 0x3C.
- Readback with `SPI_CTRL_READBACK_EN`: preload slot 2 = 0x96, then frame addr = 2, data = 0x11 → MISO returns 1,0,0,1,0,1,1,0 during the data phase, and slot 2 = 0x11 afterwards.
